// File: rtl/setpoint_scheduler_if.sv
// Command/status bundle between the UART command decoder (master) and the
// setpoint scheduler (slave). Also carries the scheduler FSM state for observation.
interface setpoint_scheduler_if #(
  parameter int DW = 14,
  parameter int AW = 4,
  parameter int CW = 24
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          dwell_wr;
  logic [CW-1:0] dwell;
  logic          len_wr;
  logic [AW:0]   len;
  logic          loop;
  logic          start;
  logic          abort;
  logic [DW-1:0] setpoint;
  logic          setpoint_stb;
  logic [AW-1:0] index;
  logic          busy;
  logic          done;
  logic          wr_err;
  logic [1:0]    state;

  modport master (
    output wr_en, wr_addr, wr_data, dwell_wr, dwell, len_wr, len, loop, start, abort,
    input  setpoint, setpoint_stb, index, busy, done, wr_err, state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, dwell_wr, dwell, len_wr, len, loop, start, abort,
    output setpoint, setpoint_stb, index, busy, done, wr_err, state
  );
endinterface

// File: rtl/setpoint_scheduler.sv
// Table-driven setpoint sequencer feeding the PID loop, one entry per dwell period.
// Optional SETPOINT_CLAMP_EN: table writes above 10000 are stored as 10000.
module setpoint_scheduler #(
  parameter int DW            = 14,
  parameter int AW            = 4,
  parameter int CW            = 24,
  parameter int DEFAULT_DWELL = 5_000_000,
  parameter int DEFAULT_LEN   = 14
) (
  input logic                 clk,
  input logic                 rst,
  setpoint_scheduler_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] DWELL  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] SP_MAX = DW'(10000);

  logic [1:0]    state;
  logic [DW-1:0] mem [DEPTH];
  logic [CW-1:0] dwell_q, cnt;
  logic [AW:0]   len_q;
  logic [AW-1:0] idx, next_idx;
  logic [DW-1:0] next_sp, sp_q, wr_val;
  logic          stb_q, done_q, err_q;
  logic          idle, cfg_wr, last, expire;

  assign idle     = (state == IDLE);
  assign cfg_wr   = bus.wr_en | bus.dwell_wr | bus.len_wr;
  assign last     = ({1'b0, idx} == len_q - (AW+1)'(1));
  assign next_idx = last ? '0 : idx + AW'(1);
  assign expire   = (cnt == dwell_q - CW'(1));

`ifdef SETPOINT_CLAMP_EN
  assign wr_val = (bus.wr_data > SP_MAX) ? SP_MAX : bus.wr_data;
`else
  assign wr_val = bus.wr_data;
`endif

  // Table has no reset so it maps onto RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && idle && bus.wr_en) mem[bus.wr_addr] <= wr_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dwell_q <= CW'(DEFAULT_DWELL);
      len_q   <= (AW+1)'(DEFAULT_LEN);
      idx     <= '0;
      cnt     <= '0;
      next_sp <= '0;
      sp_q    <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stb_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= cfg_wr && !idle;
      // Abort outranks every other event, including a coinciding dwell expiry.
      if (!idle && bus.abort) begin
        state <= IDLE;
        sp_q  <= '0;
        stb_q <= 1'b1;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.dwell_wr) dwell_q <= (bus.dwell < CW'(2)) ? CW'(2) : bus.dwell;
            if (bus.len_wr)   len_q   <= (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;
            if (bus.start && !bus.abort && len_q != '0) begin
              state <= LOAD;
              idx   <= '0;
            end
          end
          LOAD: begin
            sp_q  <= mem[idx];
            stb_q <= 1'b1;
            cnt   <= '0;
            state <= DWELL;
          end
          DWELL: begin
            // Prefetch keeps the table read off the expiry path.
            next_sp <= mem[next_idx];
            if (expire) begin
              cnt <= '0;
              if (last && !bus.loop) begin
                state  <= FINISH;
                sp_q   <= '0;
                stb_q  <= 1'b1;
                done_q <= 1'b1;
              end else begin
                idx   <= next_idx;
                sp_q  <= next_sp;
                stb_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.setpoint     = sp_q;
  assign bus.setpoint_stb = stb_q;
  assign bus.index        = idx;
  assign bus.busy         = !idle;
  assign bus.done         = done_q;
  assign bus.wr_err       = err_q;
  assign bus.state        = state;

endmodule

// File: tb/tb_setpoint_scheduler.sv
// Bench for setpoint_scheduler: scenario tasks compare logged strobe/done events
// against a timeline computed from the sequencing rules.
module tb_setpoint_scheduler;
  localparam int DW = 14, AW = 4, CW = 24, DEF_DWELL = 40, DEF_LEN = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  setpoint_scheduler_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

  setpoint_scheduler #(
    .DW(DW), .AW(AW), .CW(CW), .DEFAULT_DWELL(DEF_DWELL), .DEFAULT_LEN(DEF_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [13:0] tbl [16];
  int m_dwell, m_len;
  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int err_obs[$];
  int err_exp[$];
  bit busy_at[int];

`ifdef SETPOINT_CLAMP_EN
  localparam logic [13:0] CLAMP_EXP = 14'h2710;
`else
  localparam logic [13:0] CLAMP_EXP = 14'h3000;
`endif

  function automatic logic [13:0] clampv(input logic [13:0] d);
`ifdef SETPOINT_CLAMP_EN
    return (d > 14'd10000) ? 14'd10000 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [63:0] ev(input int c, input bit d, input int i, input logic [13:0] v);
    logic [31:0] cc;
    logic [3:0] ii;
    cc = c;
    ii = i[3:0];
    return {cc, 13'd0, d, ii, v};
  endfunction

  function automatic int first_diff();
    int n;
    n = (exp_q.size() < obs_q.size()) ? exp_q.size() : obs_q.size();
    for (int i = 0; i < n; i++) if (exp_q[i] !== obs_q[i]) return i;
    if (exp_q.size() != obs_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [63:0] obs_at(input int i);
    return (i < obs_q.size()) ? obs_q[i] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_at[cyc] = bus.busy;
    if (bus.setpoint_stb === 1'b1 || bus.done === 1'b1)
      obs_q.push_back(ev(cyc, bus.done, bus.done ? 0 : int'(bus.index), bus.setpoint));
    if (bus.wr_err === 1'b1) err_obs.push_back(cyc);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) cycle();
  endtask

  task automatic clear_logs();
    exp_q.delete();
    obs_q.delete();
    err_obs.delete();
    err_exp.delete();
  endtask

  task automatic wr_table(input int a, input logic [13:0] d);
    bit b;
    b = bus.busy;
    bus.wr_en = 1'b1; bus.wr_addr = a[3:0]; bus.wr_data = d;
    cycle();
    bus.wr_en = 1'b0;
    if (!b) tbl[a] = clampv(d);
  endtask

  task automatic wr_dwell(input int v);
    bit b;
    b = bus.busy;
    bus.dwell_wr = 1'b1; bus.dwell = v[23:0];
    cycle();
    bus.dwell_wr = 1'b0;
    if (!b) m_dwell = (v < 2) ? 2 : v;
  endtask

  task automatic wr_len(input int v);
    bit b;
    b = bus.busy;
    bus.len_wr = 1'b1; bus.len = v[4:0];
    cycle();
    bus.len_wr = 1'b0;
    if (!b) m_len = (v > 16) ? 16 : v;
  endtask

  task automatic start_run(output int t);
    t = cyc;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic abort_at(input int a);
    wait_until(a);
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
  endtask

  // Expected timeline: entry k strobes at t+2+k*dwell; done one dwell after the last
  // entry; events after stop_at are cut off (abort/reset), abort adds a zero strobe.
  task automatic expect_run(input int t, input bit loop_on, input int stop_at, input bit abort_ev);
    int k, c;
    k = 0;
    if (m_len != 0) begin
      forever begin
        c = t + 2 + k * m_dwell;
        if (stop_at >= 0 && c > stop_at) break;
        if (!loop_on && k == m_len) begin
          exp_q.push_back(ev(c, 1'b1, 0, 14'd0));
          break;
        end
        exp_q.push_back(ev(c, 1'b0, k % m_len, tbl[k % m_len]));
        k++;
      end
    end
    if (abort_ev) exp_q.push_back(ev(stop_at + 1, 1'b0, 0, 14'd0));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    n_tests++; if (bus.setpoint !== 14'd0) begin n_fail++; $display("FAIL reset_setpoint: got %h expected 0", bus.setpoint); end
    n_tests++; if (bus.setpoint_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b expected 0", bus.setpoint_stb); end
    n_tests++; if (bus.index !== 4'd0) begin n_fail++; $display("FAIL reset_index: got %0d expected 0", bus.index); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_tests++; if (bus.wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %b expected 0", bus.wr_err); end
    rst = 1'b0;
    m_dwell = DEF_DWELL;
    m_len = DEF_LEN;
    cycle();
  endtask

  task automatic test_basic();
    int t, d;
    wr_table(0, 14'h0100); wr_table(1, 14'h0200); wr_table(2, 14'h0300);
    wr_dwell(4); wr_len(3); bus.loop = 1'b0;
    clear_logs();
    start_run(t);
    expect_run(t, 1'b0, -1, 1'b0);
    wait_until(t + 20);
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL basic_events: event %0d got %h expected %h", d, obs_at(d), exp_at(d)); end
    n_tests++; if (busy_at[t + 1] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b expected 1", busy_at[t + 1]); end
    n_tests++; if (busy_at[t + 14] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_finish: got %b expected 1", busy_at[t + 14]); end
    n_tests++; if (busy_at[t + 15] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b expected 0", busy_at[t + 15]); end
  endtask

  task automatic test_loop();
    int t, d, a;
    bus.loop = 1'b1;
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      start_run(t);
      a = (r == 0) ? t + 2 + int'($urandom_range(10, 22)) : t + 2 + 4 * m_dwell - 1;
      abort_at(a);
      expect_run(t, 1'b1, a, 1'b1);
      repeat (6) cycle();
      d = first_diff();
      n_tests++; if (d >= 0) begin n_fail++; $display("FAIL loop_abort_events_%0d: event %0d got %h expected %h", r, d, obs_at(d), exp_at(d)); end
      n_tests++; if (busy_at[a + 1] !== 1'b0) begin n_fail++; $display("FAIL loop_abort_busy_%0d: got %b expected 0", r, busy_at[a + 1]); end
    end
    bus.loop = 1'b0;
  endtask

  task automatic test_busy_cmds();
    int t, d, bad;
    wr_dwell(6);
    clear_logs();
    start_run(t);
    wait_until(t + 4);
    err_exp.push_back(cyc + 1); wr_table(1, 14'h3FFF);
    err_exp.push_back(cyc + 1); wr_dwell(2);
    err_exp.push_back(cyc + 1); wr_len(1);
    bus.start = 1'b1; cycle(); bus.start = 1'b0;
    expect_run(t, 1'b0, -1, 1'b0);
    wait_until(t + 2 + 3 * 6 + 4);
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL busy_run_events: event %0d got %h expected %h", d, obs_at(d), exp_at(d)); end
    bad = (err_obs.size() != err_exp.size()) ? 1 : 0;
    for (int i = 0; i < err_exp.size() && i < err_obs.size(); i++) if (err_obs[i] != err_exp[i]) bad = 1;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL busy_wr_err: got %0d pulses expected %0d at cycles %p", err_obs.size(), err_exp.size(), err_exp); end
    clear_logs();
    start_run(t);
    expect_run(t, 1'b0, -1, 1'b0);
    wait_until(t + 2 + 3 * 6 + 4);
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL busy_rerun_events: event %0d got %h expected %h", d, obs_at(d), exp_at(d)); end
    n_tests++; if (obs_at(1)[17:0] !== {4'd1, 14'h0200}) begin n_fail++; $display("FAIL busy_rerun_entry1: got %h expected index 1 value 0200", obs_at(1)[17:0]); end
  endtask

  task automatic test_len_edges();
    int t, d;
    wr_len(0);
    clear_logs();
    start_run(t);
    repeat (10) cycle();
    n_tests++; if (obs_q.size() != 0 || busy_at[t + 1] !== 1'b0) begin n_fail++; $display("FAIL len0_start: got %0d events busy %b expected 0 events busy 0", obs_q.size(), busy_at[t + 1]); end
    wr_len(1); wr_dwell(1);
    clear_logs();
    start_run(t);
    expect_run(t, 1'b0, -1, 1'b0);
    wait_until(t + 10);
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL len1_dwell1_events: event %0d got %h expected %h", d, obs_at(d), exp_at(d)); end
    n_tests++; if (busy_at[t + 5] !== 1'b0) begin n_fail++; $display("FAIL len1_busy_fall: got %b expected 0", busy_at[t + 5]); end
  endtask

  task automatic test_start_abort();
    int t;
    wr_len(3);
    clear_logs();
    t = cyc;
    bus.start = 1'b1; bus.abort = 1'b1;
    cycle();
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (8) cycle();
    n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL start_abort_events: got %0d events expected 0", obs_q.size()); end
    n_tests++; if (busy_at[t + 1] !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %b expected 0", busy_at[t + 1]); end
  endtask

  task automatic test_random_runs();
    int t, d;
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 16; a++) wr_table(a, 14'($urandom_range(0, 16383)));
      wr_dwell($urandom_range(0, 7));
      wr_len($urandom_range(0, 20));
      clear_logs();
      start_run(t);
      expect_run(t, 1'b0, -1, 1'b0);
      wait_until(t + 2 + 17 * 7 + 4);
      d = first_diff();
      n_tests++; if (d >= 0) begin n_fail++; $display("FAIL random_run_%0d (dwell %0d len %0d): event %0d got %h expected %h", it, m_dwell, m_len, d, obs_at(d), exp_at(d)); end
    end
  endtask

  task automatic test_write_then_start();
    int t, d;
    logic [13:0] v;
    wr_len(1); wr_dwell(2);
    v = 14'($urandom_range(0, 10000));
    wr_table(0, v);
    clear_logs();
    start_run(t);
    expect_run(t, 1'b0, -1, 1'b0);
    wait_until(t + 8);
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL wr_then_start_events: event %0d got %h expected %h", d, obs_at(d), exp_at(d)); end
    wr_table(0, 14'h3000);
    clear_logs();
    start_run(t);
    expect_run(t, 1'b0, -1, 1'b0);
    wait_until(t + 8);
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL clamp_events: event %0d got %h expected %h", d, obs_at(d), exp_at(d)); end
    n_tests++; if (obs_at(0)[13:0] !== CLAMP_EXP) begin n_fail++; $display("FAIL clamp_value: got %h expected %h", obs_at(0)[13:0], CLAMP_EXP); end
  endtask

  task automatic test_reset_mid();
    int t, d, r;
    for (int a = 0; a < 16; a++) wr_table(a, 14'($urandom_range(0, 10000)));
    wr_len(3); wr_dwell(5);
    clear_logs();
    start_run(t);
    r = t + 9;
    wait_until(r);
    rst = 1'b1;
    cycle();
    n_tests++; if (bus.setpoint !== 14'd0 || bus.setpoint_stb !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got sp %h stb %b done %b expected 0 0 0", bus.setpoint, bus.setpoint_stb, bus.done); end
    n_tests++; if (bus.busy !== 1'b0 || bus.index !== 4'd0) begin n_fail++; $display("FAIL midrst_state: got busy %b index %0d expected 0 0", bus.busy, bus.index); end
    rst = 1'b0;
    expect_run(t, 1'b0, r, 1'b0);
    cycle();
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL midrst_events: event %0d got %h expected %h", d, obs_at(d), exp_at(d)); end
    m_dwell = DEF_DWELL;
    m_len = DEF_LEN;
    clear_logs();
    start_run(t);
    expect_run(t, 1'b0, -1, 1'b0);
    wait_until(t + 2 + DEF_LEN * DEF_DWELL + 4);
    d = first_diff();
    n_tests++; if (d >= 0) begin n_fail++; $display("FAIL midrst_default_run: event %0d got %h expected %h", d, obs_at(d), exp_at(d)); end
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.dwell_wr = 1'b0; bus.dwell = '0; bus.len_wr = 1'b0; bus.len = '0;
    bus.loop = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    test_reset();
    test_basic();
    test_loop();
    test_busy_cmds();
    test_len_edges();
    test_start_abort();
    test_random_runs();
    test_write_then_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/setpoint_scheduler.md
# setpoint_scheduler

Programmable setpoint sequencer that drives the 14-bit duty setpoint (0..10000 = 0.00..100.00 %) into the PID loop. The UART command decoder writes a 16-entry setpoint table, a dwell time and a sequence length into it. On a start command it plays the table out one entry per dwell period, optionally looping, and then returns the setpoint to 0. It replaces the fixed-pattern step generator as the run-time source of PID test profiles.

## Interface
- DW, 14, setpoint width
- AW, 4, table address width (depth 2^AW = 16)
- CW, 24, dwell counter width
- DEFAULT_DWELL, 5_000_000, dwell after reset (100 ms at 50 MHz)
- DEFAULT_LEN, 14, sequence length after reset

- i_Clk  in  1  clock; all logic on its rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_Wr_En  in  1  table write strobe
- i_Wr_Addr  in  AW  table write address
- i_Wr_Data  in  DW  table write data
- i_Dwell_Wr  in  1  dwell register write strobe
- i_Dwell  in  CW  dwell value in clock cycles
- i_Len_Wr  in  1  length register write strobe
- i_Len  in  AW+1  entries per pass, 0..16
- i_Loop  in  1  level; sampled at sequence end: 1 = restart at entry 0
- i_Start  in  1  one-cycle start pulse
- i_Abort  in  1  one-cycle abort pulse
- o_Setpoint  out  DW  current setpoint to PID
- o_Setpoint_Stb  out  1  one-cycle pulse whenever o_Setpoint is updated
- o_Index  out  AW  table index currently driven
- o_Busy  out  1  high outside IDLE
- o_Done  out  1  one-cycle pulse on normal completion
- o_Wr_Err  out  1  one-cycle pulse when a config write is rejected

## Operation
- States: IDLE, LOAD, DWELL, FINISH.
- IDLE
  - Config writes are accepted.
  - If i_Start=1 and len≠0, go to LOAD with index 0.
  - If i_Start=1 and len=0, ignore the start; no outputs change.
- LOAD: read table[index], then go to DWELL. On DWELL entry:
  - o_Setpoint is updated and o_Setpoint_Stb pulses.
  - Dwell counter is cleared.
- DWELL
  - The counter runs; the next entry is prefetched.
  - At expiry with index<len-1: index+1, new setpoint with a strobe.
  - At expiry with index=len-1 and i_Loop=1: index 0, new setpoint with a strobe.
  - At expiry with index=len-1 and i_Loop=0: go to FINISH.
- FINISH
  - o_Setpoint=0 with a strobe; o_Done pulses.
  - Next state is IDLE.
- Abort: i_Abort in any non-IDLE state → o_Setpoint=0 with a strobe, o_Index=0, IDLE. No o_Done.
- Busy-time commands
  - i_Wr_En, i_Dwell_Wr or i_Len_Wr while o_Busy=1: the write is dropped and o_Wr_Err pulses the next cycle.
  - i_Start while busy is ignored.
- Simultaneous events
  - i_Start and i_Abort in the same cycle: abort wins, so from IDLE nothing happens.
  - i_Abort coinciding with dwell expiry: abort wins, and there is no new-entry strobe.
- Value rules
  - i_Len values above 16 saturate to 16.
  - Dwell values below 2 are stored as 2.
- Reset
  - o_Setpoint=0, o_Setpoint_Stb=0, o_Index=0, o_Busy=0, o_Done=0, o_Wr_Err=0.
  - State IDLE; dwell=DEFAULT_DWELL; len=DEFAULT_LEN.
  - Table contents are not reset: a RAM is inferred, so entries survive i_Rst and are undefined at power-up.
  - Reset asserted mid-sequence gives the reset values on the next edge, with no strobe and no done.

## Timing
- Start accepted at cycle t:
  - t+1: o_Busy=1, state LOAD.
  - t+2: first o_Setpoint_Stb, carrying table[0].
- Consecutive setpoint strobes within a sequence, including the loop wrap, are exactly dwell cycles apart.
- Last entry's strobe at T, no loop:
  - T+dwell: FINISH, o_Setpoint=0, strobe, o_Done=1.
  - T+dwell+1: o_Busy=0.
- Abort sampled at cycle a: at a+1, o_Setpoint=0, strobe, o_Busy=0.
- Config writes take effect the cycle after the strobe. A table write followed immediately by i_Start reads the new data.

## Configuration
- SETPOINT_CLAMP_EN
  - Defined: table writes with i_Wr_Data > 10000 (14'h2710) are stored as 10000, and o_Wr_Err does not pulse for them.
  - Undefined: data is stored raw; the full 0..16383 range reaches o_Setpoint.

## Test plan
- Basic run:
  - Stimulus: write table[0..2]=0x0100,0x0200,0x0300; dwell=4; len=3; loop=0; start.
  - Required: strobes at t+2, t+6, t+10 with values 0x0100, 0x0200, 0x0300; at t+14 setpoint=0 with o_Done=1; o_Busy falls at t+15.
- Loop: same setup with i_Loop=1.
  - Required: after 0x0300 the next strobe (4 cycles later) is 0x0100 with o_Index=0.
  - Abort mid-entry: next cycle setpoint=0, o_Busy=0, no o_Done.
- Busy writes and start:
  - While running, pulse i_Wr_En at addr 1 with 0x3FFF: o_Wr_Err pulses and a later run still outputs 0x0200 at index 1.
  - i_Start while busy: no effect.
- Length edge cases:
  - len=0 then start: o_Busy stays 0.
  - len=1 with dwell=1 (stored as 2): one strobe, then done 2 cycles later.
- Reset and simultaneous pulses:
  - i_Rst during DWELL: all outputs reset next edge, dwell reads back as 5_000_000 (observed via period), and table contents are retained.
  - i_Start together with i_Abort: no run starts.
- SETPOINT_CLAMP_EN:
  - Defined: writing 0x3000 plays out as 0x2710.
  - Undefined: writing 0x3000 plays out as 0x3000.
